// File: rtl/wrr_packet_arbiter.sv
// Packet-locked weighted round-robin arbiter for one NoC output channel.
// Define WRR_WEIGHT_EN for per-port packet quotas; otherwise plain packet round robin.
module wrr_packet_arbiter #(
  parameter int ARBITER_WIDTH = 4,
  parameter int WEIGHT_W      = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ARBITER_WIDTH-1:0]          request,
  input  logic [ARBITER_WIDTH-1:0]          tail,
  input  logic [ARBITER_WIDTH*WEIGHT_W-1:0] weight_in,
  input  logic                              out_ready,
  output logic [ARBITER_WIDTH-1:0]          grant,
  output logic                              locked,
  output logic                              out_valid,
  output logic                              out_last
);
  localparam int N  = ARBITER_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   grant_nxt;
  logic [IW-1:0]  hp, hp_nxt, g, g_nxt, pick, g_inc;
  logic           found;
  logic           quota_done;

  assign out_valid = |(request & grant);
  assign out_last  = out_valid & out_ready & |(tail & grant);
  assign g_inc     = (g == IW'(N-1)) ? '0 : g + 1'b1;

  // Rotating first-set-bit search starting at hp.
  always_comb begin
    int idx;
    pick  = hp;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(hp) + i;
      if (idx >= N) idx = idx - N;
      if (!found && request[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

`ifdef WRR_WEIGHT_EN
  logic [WEIGHT_W-1:0] cnt, cnt_nxt, w_g, w_eff;

  assign w_g        = weight_in[g*WEIGHT_W +: WEIGHT_W];
  assign w_eff      = (w_g == '0) ? WEIGHT_W'(1) : w_g;
  assign quota_done = ({1'b0, cnt} + 1'b1) >= {1'b0, w_eff};
`else
  logic unused_weight;
  assign unused_weight = ^weight_in;
  assign quota_done    = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    g_nxt     = g;
    hp_nxt    = hp;
`ifdef WRR_WEIGHT_EN
    cnt_nxt   = cnt;
`endif
    case (state)
      IDLE: if (found) begin
        state_nxt       = LOCKED;
        g_nxt           = pick;
        grant_nxt       = '0;
        grant_nxt[pick] = 1'b1;
`ifdef WRR_WEIGHT_EN
        // A different port taking over starts a fresh quota.
        if (pick != hp) cnt_nxt = '0;
`endif
      end
      LOCKED: if (out_last) begin
        state_nxt = IDLE;
        grant_nxt = '0;
        if (quota_done) begin
          hp_nxt = g_inc;
`ifdef WRR_WEIGHT_EN
          cnt_nxt = '0;
`endif
        end else begin
          hp_nxt = g;
`ifdef WRR_WEIGHT_EN
          cnt_nxt = cnt + 1'b1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      locked <= 1'b0;
      g      <= '0;
      hp     <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      locked <= (state_nxt == LOCKED);
      g      <= g_nxt;
      hp     <= hp_nxt;
    end
  end

`ifdef WRR_WEIGHT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Directed bench for wrr_packet_arbiter (N=4); expected grant order follows WRR_WEIGHT_EN.
module tb_wrr_packet_arbiter;
  logic        clk, reset;
  logic [3:0]  request, tail, grant;
  logic [15:0] weight_in;
  logic        out_ready, locked, out_valid, out_last;
  int          checks = 0;
  int          errors = 0;

  wrr_packet_arbiter #(.ARBITER_WIDTH(4), .WEIGHT_W(4)) dut (
    .clk(clk), .reset(reset), .request(request), .tail(tail),
    .weight_in(weight_in), .out_ready(out_ready), .grant(grant),
    .locked(locked), .out_valid(out_valid), .out_last(out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef WRR_WEIGHT_EN
  int order[8] = '{0, 1, 1, 2, 3, 0, 1, 1};
`else
  int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
  int wrap[4] = '{0, 3, 0, 3};

  initial begin
    logic [3:0] oh;
    reset = 1'b1; request = '0; tail = '0; out_ready = 1'b0;
    weight_in = {4'd1, 4'd1, 4'd2, 4'd1};
    #1;
    check("rst_grant", grant, 4'b0000);
    check("rst_locked", locked, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // 3-flit packet on port 1 with out_ready 1,0,1,1
    request = 4'b0110;
    step();
    check("lk_grant", grant, 4'b0010);
    check("lk_locked", locked, 1'b1);
    check("lk_valid", out_valid, 1'b1);
    out_ready = 1'b1; step();
    check("lk_f1", grant, 4'b0010);
    out_ready = 1'b0; #1;
    check("lk_stall_valid", out_valid, 1'b1);
    check("lk_stall_last", out_last, 1'b0);
    step();
    check("lk_stall_grant", grant, 4'b0010);
    out_ready = 1'b1; step();
    check("lk_f2", grant, 4'b0010);
    tail = 4'b0010; #1;
    check("lk_tail_last", out_last, 1'b1);
    step();
    check("lk_bubble", grant, 4'b0000);
    check("lk_bubble_locked", locked, 1'b0);
    request = 4'b0100; tail = '0; out_ready = 1'b0; #1;
    check("lk_bubble_valid", out_valid, 1'b0);
    step();
    check("lk_next", grant, 4'b0100);
    tail = 4'b0100; out_ready = 1'b1; step();
    check("p2_release", grant, 4'b0000);

    // port 3: request drop mid-packet, then tail stalled 5 cycles
    request = 4'b1000; tail = '0; out_ready = 1'b0; step();
    check("st_grant", grant, 4'b1000);
    request = 4'b0000; out_ready = 1'b1; #1;
    check("drop_valid", out_valid, 1'b0);
    step();
    check("drop_grant", grant, 4'b1000);
    request = 4'b1000; tail = 4'b1000; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check("st_last", out_last, 1'b0);
      step();
      check("st_hold", grant, 4'b1000);
    end
    out_ready = 1'b1; #1;
    check("st_release_last", out_last, 1'b1);
    step();
    check("st_release", grant, 4'b0000);
    request = '0; tail = '0; out_ready = 1'b0;
    step();

    // continuous single-flit packets on all ports
    request = 4'b1111; tail = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      oh = 4'b0001 << order[k];
      step();
      check($sformatf("wrr_%0d", k), grant, oh);
      step();
      check($sformatf("wrr_gap_%0d", k), grant, 4'b0000);
    end
    request = '0; tail = '0; out_ready = 1'b0;
    step();

    // async reset mid-packet, then wrap/skip with only ports 0 and 3
    request = 4'b0010; step();
    check("mr_grant", grant, 4'b0010);
    #2 reset = 1'b1;
    #1;
    check("mr_grant0", grant, 4'b0000);
    check("mr_locked0", locked, 1'b0);
    check("mr_valid0", out_valid, 1'b0);
    request = 4'b1001; tail = 4'b1001; out_ready = 1'b1;
    #2 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << wrap[k];
      step();
      check($sformatf("wrap_%0d", k), grant, oh);
      step();
      check($sformatf("wrap_gap_%0d", k), grant, 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wrr_packet_arbiter.md
# wrr_packet_arbiter

Packet-locked, weighted round-robin arbiter that shares one NoC output channel among ARBITER_WIDTH input requesters. It grants one requester at a time and holds the grant for a whole wormhole packet, from first flit to tail flit. It then rotates priority, optionally after a per-port packet quota. It sits between the input-port request logic and the output-channel mux select in the router.

## Interface
- ARBITER_WIDTH, 4: number of requesters, N ≥ 2.
- WEIGHT_W, 4: width of each per-port weight field and of the quota counter.

- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- request  input  N  per-requester flit valid; bit i high means requester i has a flit ready.
- tail  input  N  per-requester tail flag, meaningful only while request[i] is high.
- weight_in  input  N*WEIGHT_W  static per-port packet quota; field i is bits [i*WEIGHT_W +: WEIGHT_W]. Value 0 is treated as 1.
- out_ready  input  1  downstream accepts a flit this cycle.
- grant  output  N  registered one-hot grant, or all zero.
- locked  output  1  registered; high while a grant is held.
- out_valid  output  1  |(request & grant).
- out_last  output  1  out_valid & out_ready & |(tail & grant).

## Operation
- State: FSM {IDLE, LOCKED}; hp is the highest-priority index (log2 N bits); cnt is the quota count (WEIGHT_W bits); g is the granted index.
- Reset values: state=IDLE, grant=0, locked=0, hp=0, cnt=0. out_valid and out_last are therefore 0.
- IDLE, request==0: no change.
- IDLE, request!=0:
  - Pick the first set bit of request, scanning hp, hp+1, … modulo N.
  - Register grant = onehot(pick), locked=1, go to LOCKED.
  - If pick != hp, set cnt=0.
- LOCKED: grant is frozen regardless of changes on request.
  - Transfer = request[g] & out_ready.
  - Packet end = transfer & tail[g], i.e. out_last.
- Packet end:
  - Clear grant and locked; go to IDLE.
  - Quota exhausted, i.e. cnt+1 ≥ max(weight_in[g],1): hp = (g+1) mod N, cnt=0.
  - Otherwise: hp = g, cnt = cnt+1.
- Wrap-around: hp rotates from N-1 to 0.
- cnt never exceeds weight-1, so it cannot overflow.
- Requester dropping request mid-packet without a tail: grant is held (out_valid=0), and no timeout is applied.
- tail high while out_ready low: not a packet end; grant is held.
- weight_in changing mid-quota takes effect at the next packet end comparison.

## Timing
- Request to grant: request sampled in IDLE at cycle t gives grant at t+1.
- Release: packet end at cycle t gives grant=0 at t+1; the next grant appears at t+2. There is one mandatory bubble cycle.
- Single-flit packets are served at most one every 2 cycles.
- out_valid and out_last are combinational from the registered grant and the current inputs.
- Reset mid-packet: grant and locked drop to 0 asynchronously; hp and cnt return to 0.

## Configuration
- WRR_WEIGHT_EN defined: per-port quotas from weight_in, as described above.
- WRR_WEIGHT_EN undefined: weight_in is ignored and cnt is not implemented. Every packet end sets hp=(g+1) mod N, giving plain packet round robin.

## Test plan
- Reset: assert reset mid-operation; grant=0000, locked=0, out_valid=0 with no clock edge; the first grant afterwards follows hp=0.
- Locked packet, N=4: request=0110 at hp=0 gives grant=0010 next cycle. Send a 3-flit packet with out_ready toggling 1,0,1,1; grant is held until tail is accepted. Then grant=0000 for one cycle, then 0100.
- Stall on tail: tail[g]=1 with out_ready=0 for 5 cycles; out_last=0 and grant unchanged; releases one cycle after out_ready=1.
- Weighted, WRR_WEIGHT_EN on: weights {p0..p3}={1,2,1,1}, all ports sending single-flit packets continuously. Grant order is 0,1,1,2,3,0,1,1.
- Unweighted, WRR_WEIGHT_EN off: same stimulus gives grant order 0,1,2,3,0,1,2,3.
- Wrap and skip: only ports 3 and 0 requesting, from hp=0. Grant order is 0,3,0,3, confirming hp wraps 3→0 and ports 1–2 are skipped.
